// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C target: FSM states, ACK/NACK levels, default address.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_e;

    localparam logic       ACK                = 1'b0;
    localparam logic       NACK               = 1'b1;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1010101;
endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one bus pin followed by an edge-detect register.
module i2c_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the idle-bus level so leaving reset does not fake an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/i2c_slave_controller.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, open-drain SDA.
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_clock_in,
    input  logic       i2c_reset_in,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic [7:0] i2c_slave_data_rx,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] i2c_slave_data_tx,
    output logic       tx_load,
    output logic       busy_out
);
    logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl (
        .clk_i(i2c_clock_in), .rst_i(i2c_reset_in), .pin_i(i2c_scl_in),
        .level_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
    );
    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
        .clk_i(i2c_clock_in), .rst_i(i2c_reset_in), .pin_i(i2c_sda_in),
        .level_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    wire start_ev = sda_fall & scl_s;
    wire stop_ev  = sda_rise & scl_s;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       full_q, full_d;     // 8 bits shifted since the last byte boundary
    logic [7:0] rxsh_q, rxsh_d, txsh_q, txsh_d, rx_q, rx_d;
    logic       oe_q, oe_d, busy_q, busy_d, rxv_q, rxv_d, txl_q, txl_d;
    logic       rw_q, rw_d, acked_q, acked_d, mack_q, mack_d;

    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        if (i2c_reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            rxsh_q  <= '0;
            txsh_q  <= '0;
            rx_q    <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rxv_q   <= 1'b0;
            txl_q   <= 1'b0;
            rw_q    <= 1'b0;
            acked_q <= 1'b0;
            mack_q  <= NACK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            rxsh_q  <= rxsh_d;
            txsh_q  <= txsh_d;
            rx_q    <= rx_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rxv_q   <= rxv_d;
            txl_q   <= txl_d;
            rw_q    <= rw_d;
            acked_q <= acked_d;
            mack_q  <= mack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        rxsh_d  = rxsh_q;
        txsh_d  = txsh_q;
        rx_d    = rx_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        rxv_d   = 1'b0;
        txl_d   = 1'b0;
        rw_d    = rw_q;
        acked_d = acked_q;
        mack_d  = mack_q;
        if (start_ev) begin
            state_d = ADDR;
            cnt_d   = '0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_ev) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (scl_rise) begin
            // ACK slots are not counted: only data states advance the counter.
            unique case (state_q)
                ADDR, WR_DATA, RD_DATA: begin
                    rxsh_d = {rxsh_q[6:0], sda_s};
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) full_d = 1'b1;
                end
                RD_ACK:  mack_d = sda_s;
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                ADDR: if (full_q) begin
                    full_d = 1'b0;
                    if (rxsh_q[7:1] == SLAVE_ADDR) begin
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        rw_d    = rxsh_q[0];
                        state_d = ADDR_ACK;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    oe_d    = 1'b0;
                    state_d = WR_DATA;
                    if (rw_q) begin
                        txl_d   = 1'b1;
                        txsh_d  = i2c_slave_data_tx;
                        oe_d    = ~i2c_slave_data_tx[7];
                        state_d = RD_DATA;
                    end
                end
                WR_DATA: if (full_q) begin
                    full_d  = 1'b0;
                    rx_d    = rxsh_q;
                    rxv_d   = 1'b1;
                    oe_d    = rx_ready;
                    acked_d = rx_ready;
                    state_d = WR_ACK;
                end
                WR_ACK: begin
                    oe_d    = 1'b0;
                    state_d = acked_q ? WR_DATA : WAIT_STOP;
                end
                RD_DATA: begin
                    if (full_q) begin
                        full_d  = 1'b0;
                        oe_d    = 1'b0;
                        state_d = RD_ACK;
                    end else begin
                        txsh_d = {txsh_q[6:0], 1'b0};
                        oe_d   = ~txsh_q[6];
                    end
                end
                RD_ACK: begin
                    if (mack_q == ACK) begin
                        txl_d   = 1'b1;
                        txsh_d  = i2c_slave_data_tx;
                        oe_d    = ~i2c_slave_data_tx[7];
                        state_d = RD_DATA;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sda_oe        = oe_q;
    assign i2c_slave_data_rx = rx_q;
    assign rx_valid          = rxv_q;
    assign tx_load           = txl_q;
    assign busy_out          = busy_q;
endmodule

// File: tb/tb_i2c_slave_controller.sv
// Directed bench: bit-banged I2C master, open-drain SDA model and rx-byte scoreboard.
module tb_i2c_slave_controller;
    import i2c_pkg::*;

    localparam int Q = 8;   // quarter SCL period in system clocks

    logic       clk = 1'b0, rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_oe, rx_valid, rx_ready = 1'b1, tx_load, busy;
    logic [7:0] data_rx, data_tx = 8'h00;
    wire        sda_line = sda_m & ~sda_oe;

    int         nchecks = 0, nerrs = 0;
    int         rx_cnt = 0, txl_cnt = 0;
    logic       oe_seen = 1'b0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    i2c_slave_controller dut (
        .i2c_clock_in(clk), .i2c_reset_in(rst), .i2c_scl_in(scl_m), .i2c_sda_in(sda_line),
        .i2c_sda_oe(sda_oe), .i2c_slave_data_rx(data_rx), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .i2c_slave_data_tx(data_tx), .tx_load(tx_load), .busy_out(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            rx_cnt++;
            if (rxq.size() == 0) chk("rx_unexpected_qsize", 32'(rxq.size()), 32'd1);
            else chk("rx_data", {24'd0, data_rx}, {24'd0, rxq.pop_front()});
        end
        if (!rst && tx_load) txl_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    initial begin
        #500_000;
        $display("FAIL timeout checks=%0d", nchecks);
        $fatal(1, "timeout");
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            sda_m = 1'b1; wq(Q);
            scl_m = 1'b1; wq(Q);
        end
        sda_m = 1'b0; wq(2*Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(2*Q);
    endtask

    task automatic put_bit(input logic b);
        wq(Q); sda_m = b; wq(Q);
        scl_m = 1'b1; wq(2*Q);
        scl_m = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wq(Q); sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        b = sda_line; wq(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         base, waited;

        wq(4);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_data_rx", {24'd0, data_rx}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        rst = 1'b0; wq(4);

        // 1: write 0xAA then 0xD3, both ACKed
        base = rx_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        chk("t1_addr_ack", {31'd0, ack}, {31'd0, ACK});
        chk("t1_busy", {31'd0, busy}, 32'd1);
        rxq.push_back(8'hD3);
        write_byte(8'hD3, ack);
        chk("t1_data_ack", {31'd0, ack}, {31'd0, ACK});
        i2c_stop();
        chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        chk("t1_rx_count", 32'(rx_cnt - base), 32'd1);

        // 2: address mismatch (7-bit 0x59, write)
        base = rx_cnt; oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hB2, ack);
        chk("t2_addr_nack", {31'd0, ack}, {31'd0, NACK});
        chk("t2_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h00, ack);
        i2c_stop();
        chk("t2_oe_never", {31'd0, oe_seen}, 32'd0);
        chk("t2_rx_count", 32'(rx_cnt - base), 32'd0);

        // 3: read 0x99 (master ACK) then 0x3C (master NACK)
        base = txl_cnt; data_tx = 8'h99;
        i2c_start();
        write_byte(8'hAB, ack);
        chk("t3_addr_ack", {31'd0, ack}, {31'd0, ACK});
        read_byte(rd);
        chk("t3_byte0", {24'd0, rd}, 32'h99);
        data_tx = 8'h3C;
        put_bit(ACK);
        read_byte(rd);
        chk("t3_byte1", {24'd0, rd}, 32'h3C);
        put_bit(NACK);
        wq(Q);
        chk("t3_wait_stop", {29'd0, dut.state_q}, {29'd0, WAIT_STOP});
        chk("t3_tx_loads", 32'(txl_cnt - base), 32'd2);
        i2c_stop();
        chk("t3_busy_after_stop", {31'd0, busy}, 32'd0);

        // 4: byte NACKed by rx_ready=0, following byte ignored
        base = rx_cnt; rx_ready = 1'b0;
        i2c_start();
        write_byte(8'hAA, ack);
        chk("t4_addr_ack", {31'd0, ack}, {31'd0, ACK});
        rxq.push_back(8'h5A);
        write_byte(8'h5A, ack);
        chk("t4_data_nack", {31'd0, ack}, {31'd0, NACK});
        write_byte(8'h11, ack);
        chk("t4_ignored_nack", {31'd0, ack}, {31'd0, NACK});
        i2c_stop();
        chk("t4_rx_count", 32'(rx_cnt - base), 32'd1);
        rx_ready = 1'b1;

        // 5: repeated START in the middle of a write byte, then read
        base = rx_cnt; data_tx = 8'h81;
        i2c_start();
        write_byte(8'hAA, ack);
        for (int i = 0; i < 4; i++) put_bit(i[0]);
        i2c_start();
        write_byte(8'hAB, ack);
        chk("t5_readdr_ack", {31'd0, ack}, {31'd0, ACK});
        chk("t5_busy", {31'd0, busy}, 32'd1);
        read_byte(rd);
        chk("t5_byte", {24'd0, rd}, 32'h81);
        put_bit(NACK);
        i2c_stop();
        chk("t5_rx_count", 32'(rx_cnt - base), 32'd0);

        // 6: reset while ACKing the address
        i2c_start();
        for (int i = 7; i >= 0; i--) put_bit(1'((8'hAA >> i) & 1));
        waited = 0;
        while (!sda_oe && waited < 4*Q) begin wq(1); waited++; end
        chk("t6_oe_before_reset", {31'd0, sda_oe}, 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("t6_oe_in_reset", {31'd0, sda_oe}, 32'd0);
        chk("t6_state_idle", {29'd0, dut.state_q}, {29'd0, IDLE});
        wq(3); rst = 1'b0; wq(4);
        rxq.push_back(8'h42);
        i2c_start();
        write_byte(8'hAA, ack);
        chk("t6_addr_ack_after_reset", {31'd0, ack}, {31'd0, ACK});
        write_byte(8'h42, ack);
        chk("t6_data_ack", {31'd0, ack}, {31'd0, ACK});
        i2c_stop();
        wq(4);
        chk("scoreboard_empty", 32'(rxq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
        $finish;
    end
endmodule
